// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the CPU/DMA memory arbiter.
//   dma_state_t : burst sequencer FSM states
//   owner_t     : tag recording which requester issued the read in a cycle
//   helper constants for word stepping, address alignment and full-word masks
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } dma_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [31:0] WORD_BYTES      = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  WMASK_ALL       = 4'b1111;

endpackage

// File: rtl/dma_burst_seq.sv
// dma_burst_seq: DMA burst address/count sequencer.
//   clk, resetn      : clock, synchronous active-low reset
//   start, we        : burst start pulse, 1 = write burst
//   addr, len        : burst start address (low two bits dropped), length in words
//   hold             : CPU owns the RAM port this cycle, so no beat may go out
//   beat, beat_we    : a DMA beat is issued this cycle, and its direction
//   beat_addr        : address of the current beat
//   busy, done       : burst in progress, one-cycle completion pulse
module dma_burst_seq
  import mem_arb_pkg::*;
#(
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [BURST_W-1:0] len,
  input  logic               hold,
  output logic               beat,
  output logic               beat_we,
  output logic [31:0]        beat_addr,
  output logic               busy,
  output logic               done
);

  dma_state_t         state_reg, state_next;
  logic [31:0]        addr_reg, addr_next;
  logic [BURST_W-1:0] count_reg, count_next;
  logic               we_reg, we_next;
  logic               beat_raw;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      we_reg    <= we_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    count_next = count_reg;
    we_next    = we_reg;
    beat_raw   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_next  = addr & WORD_ALIGN_MASK;
            count_next = len;
            we_next    = we;
            state_next = ST_BURST;
          end else begin
            // Zero-length burst: report completion without touching RAM.
            state_next = ST_DONE;
          end
        end
      end
      ST_BURST: begin
        // A CPU access steals the port; address and count simply hold.
        if (!hold) begin
          beat_raw   = 1'b1;
          addr_next  = addr_reg + WORD_BYTES;
          count_next = count_reg - BURST_W'(1);
          if (count_reg == BURST_W'(1)) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Gating with resetn keeps a burst interrupted by reset from emitting
  // anything in the reset cycle itself.
  assign beat      = beat_raw && resetn;
  assign beat_we   = we_reg;
  assign beat_addr = addr_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE) && resetn;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between a zero-wait-state CPU and a
// DMA burst engine. The CPU always wins; DMA beats fill the idle cycles.
//   clk, resetn                          : clock, synchronous active-low reset
//   cpu_addr/cpu_rstrb/cpu_wdata/cpu_wmask : CPU access request
//   cpu_rdata                            : CPU read data, cycle after cpu_rstrb
//   dma_start/dma_we/dma_addr/dma_len    : burst request
//   dma_wdata, dma_wready                : write word and its consume strobe
//   dma_rvalid, dma_rdata                : read word return
//   dma_busy, dma_done                   : burst status
//   ram_addr/ram_en/ram_wmask/ram_wdata  : RAM port, ram_rdata one cycle later
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [31:0]        cpu_addr,
  input  logic               cpu_rstrb,
  input  logic [31:0]        cpu_wdata,
  input  logic [3:0]         cpu_wmask,
  output logic [31:0]        cpu_rdata,
  input  logic               dma_start,
  input  logic               dma_we,
  input  logic [31:0]        dma_addr,
  input  logic [BURST_W-1:0] dma_len,
  input  logic [31:0]        dma_wdata,
  output logic               dma_wready,
  output logic               dma_rvalid,
  output logic [31:0]        dma_rdata,
  output logic               dma_busy,
  output logic               dma_done,
  output logic [31:0]        ram_addr,
  output logic               ram_en,
  output logic [3:0]         ram_wmask,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  logic        cpu_access;
  logic        beat;
  logic        beat_we;
  logic [31:0] beat_addr;
  owner_t      owner_reg, owner_next;
  logic [31:0] hold_reg;

  assign cpu_access = resetn && (cpu_rstrb || (cpu_wmask != 4'b0000));

  dma_burst_seq #(
    .BURST_W (BURST_W)
  ) u_seq (
    .clk       (clk),
    .resetn    (resetn),
    .start     (dma_start),
    .we        (dma_we),
    .addr      (dma_addr),
    .len       (dma_len),
    .hold      (cpu_access),
    .beat      (beat),
    .beat_we   (beat_we),
    .beat_addr (beat_addr),
    .busy      (dma_busy),
    .done      (dma_done)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = '0;
    ram_wmask = 4'b0000;
    ram_wdata = '0;
    if (cpu_access) begin
      ram_en    = 1'b1;
      ram_addr  = cpu_addr;
      ram_wmask = cpu_wmask;
      ram_wdata = cpu_wdata;
    end else if (beat) begin
      ram_en    = 1'b1;
      ram_addr  = beat_addr;
      ram_wmask = beat_we ? WMASK_ALL : 4'b0000;
      ram_wdata = dma_wdata;
    end
  end

  assign dma_wready = beat && beat_we;

  // Tag who issued a read this cycle, so next cycle's ram_rdata is routed
  // to the right requester.
  always_comb begin
    owner_next = OWN_NONE;
    if (cpu_access && cpu_rstrb) begin
      owner_next = OWN_CPU;
    end else if (beat && !beat_we) begin
      owner_next = OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_reg <= OWN_NONE;
      hold_reg  <= '0;
    end else begin
      owner_reg <= owner_next;
      if (owner_reg == OWN_CPU) begin
        hold_reg <= ram_rdata;
      end
    end
  end

  // The CPU sees live RAM data only on its own return cycle; otherwise the
  // hold register shields it from DMA read traffic.
  assign cpu_rdata  = (owner_reg == OWN_CPU) ? ram_rdata : hold_reg;
  assign dma_rvalid = (owner_reg == OWN_DMA) && resetn;
  assign dma_rdata  = dma_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic [31:0] cpu_addr;
  logic        cpu_rstrb;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_rdata;
  logic        dma_start;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [7:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_wready;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_busy;
  logic        dma_done;
  logic [31:0] ram_addr;
  logic        ram_en;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_cmp;
  int n_bad;

  mem_arbiter #(.BURST_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_addr   (cpu_addr),
    .cpu_rstrb  (cpu_rstrb),
    .cpu_wdata  (cpu_wdata),
    .cpu_wmask  (cpu_wmask),
    .cpu_rdata  (cpu_rdata),
    .dma_start  (dma_start),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_wready (dma_wready),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done),
    .ram_addr   (ram_addr),
    .ram_en     (ram_en),
    .ram_wmask  (ram_wmask),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM content is a fixed function of the address.
  function automatic logic [31:0] ramval(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  initial ram_rdata = '0;
  always @(posedge clk) if (ram_en) ram_rdata <= ramval(ram_addr);

  task automatic idle_inputs();
    cpu_addr = '0; cpu_rstrb = 1'b0; cpu_wdata = '0; cpu_wmask = 4'b0;
    dma_start = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++; if (ram_en !== 1'b0)     begin n_bad++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
    n_cmp++; if (dma_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", dma_busy); end
    n_cmp++; if (dma_done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", dma_done); end
    n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", dma_rvalid); end
    n_cmp++; if (dma_wready !== 1'b0) begin n_bad++; $display("FAIL reset_wready: got %b want 0", dma_wready); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_dma_read();
    logic [6:0]  e_en   = 7'b0011110;
    logic [6:0]  e_rv   = 7'b0111100;
    logic [6:0]  e_done = 7'b0100000;
    logic [6:0]  e_busy = 7'b0111110;
    logic [31:0] a_exp  = 32'h100;
    logic [31:0] r_exp  = 32'h100;
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      dma_start = (c == 0); dma_addr = 32'h102; dma_len = 8'd4;
      @(negedge clk);
      n_cmp++; if (ram_en !== e_en[c]) begin n_bad++; $display("FAIL rd_en c%0d: got %b want %b", c, ram_en, e_en[c]); end
      if (e_en[c]) begin
        n_cmp++; if (ram_addr !== a_exp) begin n_bad++; $display("FAIL rd_addr c%0d: got %h want %h", c, ram_addr, a_exp); end
        n_cmp++; if (ram_wmask !== 4'b0) begin n_bad++; $display("FAIL rd_wmask c%0d: got %b want 0000", c, ram_wmask); end
        a_exp = a_exp + 32'd4;
      end
      n_cmp++; if (dma_wready !== 1'b0) begin n_bad++; $display("FAIL rd_wready c%0d: got %b want 0", c, dma_wready); end
      n_cmp++; if (dma_rvalid !== e_rv[c]) begin n_bad++; $display("FAIL rd_rvalid c%0d: got %b want %b", c, dma_rvalid, e_rv[c]); end
      if (e_rv[c]) begin
        n_cmp++; if (dma_rdata !== ramval(r_exp)) begin n_bad++; $display("FAIL rd_rdata c%0d: got %h want %h", c, dma_rdata, ramval(r_exp)); end
        r_exp = r_exp + 32'd4;
      end
      n_cmp++; if (dma_done !== e_done[c]) begin n_bad++; $display("FAIL rd_done c%0d: got %b want %b", c, dma_done, e_done[c]); end
      n_cmp++; if (dma_busy !== e_busy[c]) begin n_bad++; $display("FAIL rd_busy c%0d: got %b want %b", c, dma_busy, e_busy[c]); end
      @(posedge clk); #1;
    end
    $display("test_dma_read done");
  endtask

  task automatic test_dma_write_preempt();
    logic [6:0]  e_en   = 7'b0011110;
    logic [6:0]  e_wr   = 7'b0011010;
    logic [6:0]  e_done = 7'b0100000;
    logic [6:0]  e_busy = 7'b0111110;
    logic [31:0] a_exp  = 32'h200;
    int          idx    = 0;
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      dma_start = (c == 0); dma_we = 1'b1; dma_addr = 32'h200; dma_len = 8'd3;
      dma_wdata = 32'hCAFE_0000 + idx;
      if (c == 2) begin cpu_wmask = 4'b0011; cpu_addr = 32'h40; cpu_wdata = 32'h1122_3344; end
      @(negedge clk);
      n_cmp++; if (ram_en !== e_en[c]) begin n_bad++; $display("FAIL wr_en c%0d: got %b want %b", c, ram_en, e_en[c]); end
      if (c == 2) begin
        n_cmp++; if (ram_addr !== 32'h40) begin n_bad++; $display("FAIL wr_cpu_addr: got %h want 00000040", ram_addr); end
        n_cmp++; if (ram_wmask !== 4'b0011) begin n_bad++; $display("FAIL wr_cpu_wmask: got %b want 0011", ram_wmask); end
        n_cmp++; if (ram_wdata !== 32'h1122_3344) begin n_bad++; $display("FAIL wr_cpu_wdata: got %h want 11223344", ram_wdata); end
      end else if (e_en[c]) begin
        n_cmp++; if (ram_addr !== a_exp) begin n_bad++; $display("FAIL wr_addr c%0d: got %h want %h", c, ram_addr, a_exp); end
        n_cmp++; if (ram_wmask !== 4'b1111) begin n_bad++; $display("FAIL wr_wmask c%0d: got %b want 1111", c, ram_wmask); end
        n_cmp++; if (ram_wdata !== 32'hCAFE_0000 + idx) begin n_bad++; $display("FAIL wr_wdata c%0d: got %h want %h", c, ram_wdata, 32'hCAFE_0000 + idx); end
        a_exp = a_exp + 32'd4;
      end
      n_cmp++; if (dma_wready !== e_wr[c]) begin n_bad++; $display("FAIL wr_wready c%0d: got %b want %b", c, dma_wready, e_wr[c]); end
      n_cmp++; if (dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid c%0d: got %b want 0", c, dma_rvalid); end
      n_cmp++; if (dma_done !== e_done[c]) begin n_bad++; $display("FAIL wr_done c%0d: got %b want %b", c, dma_done, e_done[c]); end
      n_cmp++; if (dma_busy !== e_busy[c]) begin n_bad++; $display("FAIL wr_busy c%0d: got %b want %b", c, dma_busy, e_busy[c]); end
      if (e_wr[c]) idx++;
      @(posedge clk); #1;
    end
    $display("test_dma_write_preempt done");
  endtask

  task automatic test_cpu_hold();
    logic [31:0] want;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      dma_start = (c == 0); dma_addr = 32'h300; dma_len = 8'd1;
      if (c == 0) begin cpu_rstrb = 1'b1; cpu_addr = 32'h80; end
      if (c == 4) begin cpu_rstrb = 1'b1; cpu_addr = 32'h84; end
      @(negedge clk);
      if (c == 0 || c == 4) begin
        n_cmp++; if (ram_addr !== cpu_addr || ram_en !== 1'b1) begin n_bad++; $display("FAIL hold_cpu_port c%0d: got en=%b addr=%h want en=1 addr=%h", c, ram_en, ram_addr, cpu_addr); end
      end
      if (c == 1) begin
        n_cmp++; if (ram_en !== 1'b1 || ram_addr !== 32'h300) begin n_bad++; $display("FAIL hold_beat: got en=%b addr=%h want en=1 addr=00000300", ram_en, ram_addr); end
      end
      if (c == 2) begin
        n_cmp++; if (dma_rvalid !== 1'b1 || dma_rdata !== ramval(32'h300)) begin n_bad++; $display("FAIL hold_dma_rdata: got v=%b d=%h want v=1 d=%h", dma_rvalid, dma_rdata, ramval(32'h300)); end
        n_cmp++; if (dma_done !== 1'b1) begin n_bad++; $display("FAIL hold_done: got %b want 1", dma_done); end
      end
      if (c >= 1) begin
        want = (c == 5) ? ramval(32'h84) : ramval(32'h80);
        n_cmp++; if (cpu_rdata !== want) begin n_bad++; $display("FAIL hold_cpu_rdata c%0d: got %h want %h", c, cpu_rdata, want); end
      end
      @(posedge clk); #1;
    end
    $display("test_cpu_hold done");
  endtask

  task automatic test_zero_len_busy();
    logic [8:0]  e_en   = 9'b000110000;
    logic [8:0]  e_rv   = 9'b001100000;
    logic [8:0]  e_done = 9'b001000010;
    logic [8:0]  e_busy = 9'b001110010;
    logic [31:0] a_exp  = 32'h400;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      dma_start = (c == 0 || c == 1 || (c >= 3 && c <= 6));
      dma_addr  = (c == 3) ? 32'h400 : 32'h800;
      dma_len   = (c == 0) ? 8'd0 : ((c <= 3) ? 8'd2 : 8'd5);
      @(negedge clk);
      n_cmp++; if (ram_en !== e_en[c]) begin n_bad++; $display("FAIL zl_en c%0d: got %b want %b", c, ram_en, e_en[c]); end
      if (e_en[c]) begin
        n_cmp++; if (ram_addr !== a_exp) begin n_bad++; $display("FAIL zl_addr c%0d: got %h want %h", c, ram_addr, a_exp); end
        a_exp = a_exp + 32'd4;
      end
      n_cmp++; if (dma_rvalid !== e_rv[c]) begin n_bad++; $display("FAIL zl_rvalid c%0d: got %b want %b", c, dma_rvalid, e_rv[c]); end
      n_cmp++; if (dma_done !== e_done[c]) begin n_bad++; $display("FAIL zl_done c%0d: got %b want %b", c, dma_done, e_done[c]); end
      n_cmp++; if (dma_busy !== e_busy[c]) begin n_bad++; $display("FAIL zl_busy c%0d: got %b want %b", c, dma_busy, e_busy[c]); end
      @(posedge clk); #1;
    end
    $display("test_zero_len_busy done");
  endtask

  task automatic test_wrap();
    logic [5:0]  e_en   = 6'b001110;
    logic [5:0]  e_rv   = 6'b011100;
    logic [5:0]  e_done = 6'b010000;
    logic [31:0] a_exp  = 32'hFFFF_FFF8;
    logic [31:0] r_exp  = 32'hFFFF_FFF8;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      dma_start = (c == 0); dma_addr = 32'hFFFF_FFF8; dma_len = 8'd3;
      @(negedge clk);
      n_cmp++; if (ram_en !== e_en[c]) begin n_bad++; $display("FAIL wrap_en c%0d: got %b want %b", c, ram_en, e_en[c]); end
      if (e_en[c]) begin
        n_cmp++; if (ram_addr !== a_exp) begin n_bad++; $display("FAIL wrap_addr c%0d: got %h want %h", c, ram_addr, a_exp); end
        a_exp = a_exp + 32'd4;
      end
      n_cmp++; if (dma_rvalid !== e_rv[c]) begin n_bad++; $display("FAIL wrap_rvalid c%0d: got %b want %b", c, dma_rvalid, e_rv[c]); end
      if (e_rv[c]) begin
        n_cmp++; if (dma_rdata !== ramval(r_exp)) begin n_bad++; $display("FAIL wrap_rdata c%0d: got %h want %h", c, dma_rdata, ramval(r_exp)); end
        r_exp = r_exp + 32'd4;
      end
      n_cmp++; if (dma_done !== e_done[c]) begin n_bad++; $display("FAIL wrap_done c%0d: got %b want %b", c, dma_done, e_done[c]); end
      @(posedge clk); #1;
    end
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid_burst();
    logic [8:0]  e_en   = 9'b000000110;
    logic [8:0]  e_rv   = 9'b000000100;
    logic [8:0]  e_busy = 9'b000000110;
    logic [31:0] a_exp  = 32'h500;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      resetn = (c != 3);
      dma_start = (c == 0); dma_addr = 32'h500; dma_len = 8'd5;
      @(negedge clk);
      n_cmp++; if (ram_en !== e_en[c]) begin n_bad++; $display("FAIL rst_en c%0d: got %b want %b", c, ram_en, e_en[c]); end
      if (e_en[c]) begin
        n_cmp++; if (ram_addr !== a_exp) begin n_bad++; $display("FAIL rst_addr c%0d: got %h want %h", c, ram_addr, a_exp); end
        a_exp = a_exp + 32'd4;
      end
      n_cmp++; if (dma_done !== 1'b0) begin n_bad++; $display("FAIL rst_done c%0d: got %b want 0", c, dma_done); end
      if (c != 3) begin
        n_cmp++; if (dma_rvalid !== e_rv[c]) begin n_bad++; $display("FAIL rst_rvalid c%0d: got %b want %b", c, dma_rvalid, e_rv[c]); end
        n_cmp++; if (dma_busy !== e_busy[c]) begin n_bad++; $display("FAIL rst_busy c%0d: got %b want %b", c, dma_busy, e_busy[c]); end
      end
      @(posedge clk); #1;
    end
    resetn = 1'b1;
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_dma_read();
    test_dma_write_preempt();
    test_cpu_hold();
    test_zero_len_busy();
    test_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
